// File: rtl/frame_buf_scan_reader.sv
// frame_buf_scan_reader: scan-out read side of the 160x120x24 frame buffer.
// Readback port is built only when FRAME_BUF_READBACK_EN is defined.
module frame_buf_scan_reader #(
  parameter int MEMORY_SIZE         = 19200,
  parameter int VIRTUAL_PIXEL_WIDTH = 160,
  parameter int PIXEL_VIRTUAL_SIZE  = 4,
  parameter int RD_LATENCY          = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active_pixels,
  input  logic        frame_done,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [14:0] mem_rd_address,
  input  logic [23:0] mem_rd_data,
  output logic [23:0] pix_rgb,
  output logic        pix_valid,
  input  logic        rb_req,
  input  logic [14:0] rb_address,
  output logic        rb_busy,
  output logic [23:0] rb_data,
  output logic        rb_valid
);

  localparam int SH = $clog2(PIXEL_VIRTUAL_SIZE);
  localparam int PD = 1 + RD_LATENCY;
  // row width 160 = 128 + 32, so the multiply is two shifts
  localparam int ROW_HI = $clog2(VIRTUAL_PIXEL_WIDTH) - 1;
  localparam int ROW_LO = $clog2(VIRTUAL_PIXEL_WIDTH - (1 << ROW_HI));

  generate
    if (MEMORY_SIZE > 32768 || RD_LATENCY < 1) begin : g_bad_cfg
      $error("frame_buf_scan_reader: unsupported configuration");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SCAN, RB_ISSUE, RB_WAIT} state_t;

  state_t        state, state_nx;
  logic [9:0]    vx, vy;
  logic [14:0]   addr_nx, scan_addr;
  logic [PD-1:0] vpipe;
  logic          slot;
  logic          accept, oor, last;

  assign vx      = x >> SH;
  assign vy      = y >> SH;
  assign addr_nx = (15'(vy) << ROW_HI) + (15'(vy) << ROW_LO) + 15'(vx);
  // samples taken outside SCAN (idle or readback) never become pixels
  assign slot    = active_pixels && (state == SCAN);

  // Scan address stage and matching visibility delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_addr <= '0;
      vpipe     <= '0;
    end else begin
      scan_addr <= addr_nx;
      vpipe     <= {vpipe[PD-2:0], slot};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

`ifdef FRAME_BUF_READBACK_EN
  localparam int              CW       = $clog2(RD_LATENCY + 1);
  localparam logic [15:0]     MEM_LIM  = 16'(MEMORY_SIZE);
  localparam logic [CW-1:0]   CNT_LAST = CW'(RD_LATENCY - 1);

  state_t        ret_q;
  logic [14:0]   rb_addr_q;
  logic [CW-1:0] cnt;

  assign accept = rb_req && !rb_busy && (state == IDLE || state == SCAN);
  assign oor    = {1'b0, rb_addr_q} >= MEM_LIM;
  assign last   = cnt == CNT_LAST;

  // Readback request latch, latency counter and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_q     <= IDLE;
      rb_addr_q <= '0;
      cnt       <= '0;
      rb_data   <= '0;
      rb_valid  <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      cnt      <= (state == RB_WAIT) ? cnt + CW'(1) : '0;
      if (accept) begin
        rb_addr_q <= rb_address;
        ret_q     <= (state == SCAN || frame_done) ? SCAN : IDLE;
      end
      if (state == RB_ISSUE && oor) begin
        rb_data  <= '0;
        rb_valid <= 1'b1;
      end
      if (state == RB_WAIT && last) begin
        rb_data  <= mem_rd_data;
        rb_valid <= 1'b1;
      end
    end
  end

  // Readback acceptance: only idle, or scan during blanking
  always_comb begin
    rb_busy = 1'b1;
    if (!rst)                rb_busy = 1'b1;
    else if (state == IDLE)  rb_busy = 1'b0;
    else if (state == SCAN)  rb_busy = active_pixels;
  end
`else
  logic unused_rb;

  assign accept    = 1'b0;
  assign oor       = 1'b0;
  assign last      = 1'b0;
  assign unused_rb = ^{rb_req, rb_address, oor, last};
  assign rb_busy   = 1'b1;
  assign rb_data   = '0;
  assign rb_valid  = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)          state_nx = RB_ISSUE;
        else if (frame_done) state_nx = SCAN;
      end
      SCAN: begin
        if (accept) state_nx = RB_ISSUE;
      end
`ifdef FRAME_BUF_READBACK_EN
      RB_ISSUE: state_nx = oor ? ret_q : RB_WAIT;
      RB_WAIT: begin
        if (last) state_nx = ret_q;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: read port mux and aligned pixel stream
  always_comb begin
    pix_valid      = vpipe[PD-1];
    pix_rgb        = vpipe[PD-1] ? mem_rd_data : 24'h0;
    mem_rd_address = scan_addr;
`ifdef FRAME_BUF_READBACK_EN
    if (state == RB_ISSUE) mem_rd_address = rb_addr_q;
`endif
  end

endmodule

// File: tb/tb_frame_buf_scan_reader.sv
// tb_frame_buf_scan_reader: vector table, hand sequences and random
// stimulus against a cycle-level behavioural model of the reader.
module tb_frame_buf_scan_reader;

  localparam int L     = 2;
  localparam int PD    = 1 + L;
  localparam int MEMSZ = 19200;
`ifdef FRAME_BUF_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        active_pixels;
  logic        frame_done;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [14:0] mem_rd_address;
  logic [23:0] mem_rd_data;
  logic [23:0] pix_rgb;
  logic        pix_valid;
  logic        rb_req;
  logic [14:0] rb_address;
  logic        rb_busy;
  logic [23:0] rb_data;
  logic        rb_valid;

  frame_buf_scan_reader dut (
    .clk(clk), .rst(rst),
    .active_pixels(active_pixels), .frame_done(frame_done),
    .x(x), .y(y),
    .mem_rd_address(mem_rd_address), .mem_rd_data(mem_rd_data),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .rb_req(rb_req), .rb_address(rb_address),
    .rb_busy(rb_busy), .rb_data(rb_data), .rb_valid(rb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] memf(input logic [14:0] a);
    if (a == 15'd19199) return 24'hABCDEF;
    if (a == 15'd161)   return 24'h123456;
    return {a[7:0] ^ 8'h3C, 1'b1, a[14:8], a[7:0] + 8'h11};
  endfunction

  logic [14:0] apipe [L];
  initial for (int i = 0; i < L; i++) apipe[i] = '0;
  always @(posedge clk) begin
    apipe[0] <= mem_rd_address;
    for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
  end
  assign mem_rd_data = memf(apipe[L-1]);

  int n_pass = 0;
  int n_total = 0;
  int cycn = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_total++;
    if (got !== want)
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cycn, got, want);
    else
      n_pass++;
  endtask

  typedef struct { bit v; logic [14:0] a; } samp_t;
  samp_t       hist[$];
  bit          m_scan;
  int          m_rb_cyc, m_rb_len, m_rbv_cyc;
  logic [14:0] m_rb_addr;
  bit          m_tgt;
  logic [23:0] m_rb_data, m_rbv_val;
  bit          last_acc;

  logic        s_busy, s_rbv, s_pv;
  logic [23:0] s_rbd, s_rgb;
  logic [14:0] s_addr;

  task automatic model_reset();
    hist.delete();
    repeat (PD) hist.push_back('{1'b0, 15'd0});
    m_scan    = 1'b0;
    m_rb_cyc  = 0;
    m_rb_len  = 0;
    m_rbv_cyc = -1;
    m_rb_data = '0;
    m_rbv_val = '0;
    m_rb_addr = '0;
    m_tgt     = 1'b0;
  endtask

  task automatic chk_rst();
    chk("rst_addr", 32'(mem_rd_address), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_pix_rgb", 32'(pix_rgb), 0);
    chk("rst_rb_busy", 32'(rb_busy), 1);
    chk("rst_rb_valid", 32'(rb_valid), 0);
    chk("rst_rb_data", 32'(rb_data), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    active_pixels = 1'b0; frame_done = 1'b0;
    rb_req = 1'b0; rb_address = '0; x = '0; y = '0;
    model_reset();
    #1;
    chk_rst();
    repeat (n) begin
      @(posedge clk); #1;
      chk_rst();
    end
    rst = 1'b1;
  endtask

  task automatic cyc(input bit act, input bit fd, input int cx, input int cy,
                     input bit rq, input int ra);
    samp_t       old;
    bit          in_rb, issue, e_busy, e_rbv, oor;
    logic [14:0] e_addr, sa;
    logic [23:0] e_rgb;
    active_pixels = act; frame_done = fd;
    x = 10'(cx); y = 10'(cy);
    rb_req = rq; rb_address = 15'(ra);
    in_rb  = m_rb_cyc > 0;
    issue  = m_rb_cyc == 1;
    old    = hist[0];
    e_addr = issue ? m_rb_addr : hist[PD-1].a;
    e_rgb  = old.v ? memf(old.a) : 24'h0;
    e_busy = RB_EN ? (in_rb || (m_scan && act)) : 1'b1;
    e_rbv  = cycn == m_rbv_cyc;
    if (e_rbv) m_rb_data = m_rbv_val;
    @(negedge clk);
    s_addr = mem_rd_address; s_pv = pix_valid; s_rgb = pix_rgb;
    s_busy = rb_busy; s_rbv = rb_valid; s_rbd = rb_data;
    chk("addr", 32'(s_addr), 32'(e_addr));
    chk("pix_valid", 32'(s_pv), 32'(old.v));
    chk("pix_rgb", 32'(s_rgb), 32'(e_rgb));
    chk("rb_busy", 32'(s_busy), 32'(e_busy));
    chk("rb_valid", 32'(s_rbv), 32'(e_rbv));
    chk("rb_data", 32'(s_rbd), 32'(m_rb_data));
    sa = 15'((cy / 4) * 160 + cx / 4);
    void'(hist.pop_front());
    hist.push_back('{act && m_scan && !in_rb, sa});
    last_acc = RB_EN && rq && !e_busy;
    if (in_rb) begin
      if (m_rb_cyc == m_rb_len) begin
        m_rb_cyc = 0;
        m_scan   = m_tgt;
      end else begin
        m_rb_cyc++;
      end
    end else if (last_acc) begin
      oor       = ra >= MEMSZ;
      m_rb_cyc  = 1;
      m_rb_len  = oor ? 1 : 1 + L;
      m_rb_addr = 15'(ra);
      m_tgt     = m_scan || fd;
      m_rbv_cyc = cycn + (oor ? 2 : 2 + L);
      m_rbv_val = oor ? 24'h0 : memf(15'(ra));
    end else if (fd) begin
      m_scan = 1'b1;
    end
    cycn++;
    @(posedge clk); #1;
  endtask

  task automatic wait_rbv(input bit act, output int n);
    n = 0;
    do begin
      cyc(act, 1'b0, 20, 30, 1'b0, 0);
      n++;
    end while (!s_rbv && n < 10);
  endtask

  typedef struct {
    bit act; bit fd; int x; int y;
    logic [14:0] e_addr; bit e_pv; logic [23:0] e_rgb;
  } vec_t;
  vec_t tv [18];

  int n, i_act, i_fd, pa;
  bit any, pend;

  initial begin
    tv[0]  = '{1'b0, 1'b1, 0,   0,   15'd0,     1'b0, 24'h0};
    tv[1]  = '{1'b1, 1'b0, 0,   0,   15'd0,     1'b0, 24'h0};
    tv[2]  = '{1'b1, 1'b0, 1,   0,   15'd0,     1'b0, 24'h0};
    tv[3]  = '{1'b1, 1'b0, 2,   0,   15'd0,     1'b0, 24'h0};
    tv[4]  = '{1'b1, 1'b0, 3,   0,   15'd0,     1'b1, memf(0)};
    tv[5]  = '{1'b1, 1'b0, 4,   0,   15'd0,     1'b1, memf(0)};
    tv[6]  = '{1'b1, 1'b0, 5,   0,   15'd1,     1'b1, memf(0)};
    tv[7]  = '{1'b1, 1'b0, 6,   0,   15'd1,     1'b1, memf(0)};
    tv[8]  = '{1'b1, 1'b0, 7,   0,   15'd1,     1'b1, memf(1)};
    tv[9]  = '{1'b0, 1'b0, 0,   0,   15'd1,     1'b1, memf(1)};
    tv[10] = '{1'b1, 1'b0, 639, 479, 15'd0,     1'b1, memf(1)};
    tv[11] = '{1'b0, 1'b0, 0,   0,   15'd19199, 1'b1, memf(1)};
    tv[12] = '{1'b0, 1'b0, 0,   0,   15'd0,     1'b0, 24'h0};
    tv[13] = '{1'b0, 1'b0, 0,   0,   15'd0,     1'b1, 24'hABCDEF};
    tv[14] = '{1'b0, 1'b0, 4,   4,   15'd0,     1'b0, 24'h0};
    tv[15] = '{1'b0, 1'b0, 637, 0,   15'd161,   1'b0, 24'h0};
    tv[16] = '{1'b0, 1'b0, 0,   479, 15'd159,   1'b0, 24'h0};
    tv[17] = '{1'b0, 1'b0, 0,   0,   15'd19040, 1'b0, 24'h0};

    rst = 1'b0;
    active_pixels = 1'b0; frame_done = 1'b0;
    rb_req = 1'b0; rb_address = '0; x = '0; y = '0;
    @(posedge clk); #1;
    do_reset(3);

    for (int i = 0; i < 18; i++) begin
      cyc(tv[i].act, tv[i].fd, tv[i].x, tv[i].y, 1'b0, 0);
      chk("tv_addr", 32'(s_addr), 32'(tv[i].e_addr));
      chk("tv_pix_valid", 32'(s_pv), 32'(tv[i].e_pv));
      chk("tv_pix_rgb", 32'(s_rgb), 32'(tv[i].e_rgb));
    end

`ifdef FRAME_BUF_READBACK_EN
    cyc(1'b0, 1'b0, 8, 8, 1'b1, 161);
    chk("rb_accept_busy", 32'(s_busy), 0);
    cyc(1'b0, 1'b0, 8, 8, 1'b0, 0);
    chk("rb_issue_addr", 32'(s_addr), 161);
    chk("rb_issue_busy", 32'(s_busy), 1);
    wait_rbv(1'b0, n);
    chk("rb_latency", 32'(n), 32'(L + 1));
    chk("rb_result", 32'(s_rbd), 32'h123456);
    cyc(1'b0, 1'b0, 8, 8, 1'b0, 0);
    chk("rb_single_pulse", 32'(s_rbv), 0);
    chk("rb_hold", 32'(s_rbd), 32'h123456);

    cyc(1'b0, 1'b0, 8, 8, 1'b1, 19200);
    cyc(1'b0, 1'b0, 8, 8, 1'b0, 0);
    chk("oor_issue_addr", 32'(s_addr), 19200);
    cyc(1'b0, 1'b0, 8, 8, 1'b0, 0);
    chk("oor_valid", 32'(s_rbv), 1);
    chk("oor_data", 32'(s_rbd), 0);

    repeat (4) begin
      cyc(1'b1, 1'b0, 100, 200, 1'b1, 300);
      chk("rb_blocked_busy", 32'(s_busy), 1);
    end
    cyc(1'b0, 1'b0, 100, 200, 1'b1, 300);
    chk("rb_blank_accept", 32'(s_busy), 0);
    cyc(1'b0, 1'b0, 100, 200, 1'b0, 0);
    chk("rb2_issue_addr", 32'(s_addr), 300);
    wait_rbv(1'b1, n);
    chk("rb2_latency", 32'(n), 32'(L + 1));
    chk("rb2_result", 32'(s_rbd), 32'(memf(300)));
    cyc(1'b1, 1'b0, 20, 30, 1'b0, 0);
    chk("conflict_pv_a", 32'(s_pv), 0);
    cyc(1'b1, 1'b0, 20, 30, 1'b0, 0);
    chk("conflict_pv_b", 32'(s_pv), 0);
    cyc(1'b1, 1'b0, 20, 30, 1'b0, 0);
    chk("conflict_resume", 32'(s_pv), 1);
`else
    repeat (6) begin
      cyc(1'b0, 1'b0, 8, 8, 1'b1, 161);
      chk("rb_off_busy", 32'(s_busy), 1);
      chk("rb_off_valid", 32'(s_rbv), 0);
      chk("rb_off_data", 32'(s_rbd), 0);
    end
`endif

    cyc(1'b0, 1'b0, 12, 40, 1'b1, 500);
    cyc(1'b0, 1'b0, 12, 40, 1'b0, 0);
    cyc(1'b0, 1'b0, 12, 40, 1'b0, 0);
    do_reset(2);
    any = 1'b0;
    repeat (6) begin
      cyc(1'b1, 1'b0, 12, 40, 1'b0, 0);
      any = any | s_rbv;
    end
    chk("rst_no_rb_valid", 32'(any), 0);
    chk("rst_idle_busy", 32'(s_busy), RB_EN ? 32'd0 : 32'd1);
    chk("rst_idle_pv", 32'(s_pv), 0);

    do_reset(2);
    pend = 1'b0;
    pa = 0;
    for (int i = 0; i < 3000; i++) begin
      i_act = ($urandom_range(0, 9) < 7) ? 1 : 0;
      i_fd  = ($urandom_range(0, 99) == 0) ? 1 : 0;
      if (!pend && $urandom_range(0, 19) == 0) begin
        pend = 1'b1;
        if ($urandom_range(0, 9) == 0) pa = $urandom_range(19200, 32767);
        else                           pa = $urandom_range(0, 19199);
      end
      cyc(i_act != 0, i_fd != 0, $urandom_range(0, 639),
          $urandom_range(0, 479), pend, pa);
      if (last_acc || !RB_EN) pend = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
